pipe_scroller: RTL and testbench

//  Parametrised pipe-field generator for the Flappy Bird LED matrix. It supersedes the single fixed 8-pattern pipe

---
 rtl/flappy_pkg.sv | 26 ++
 rtl/pipe_scroller_if.sv | 28 ++
 rtl/pipe_scroller_lfsr_gap_gen.sv | 34 +++
 rtl/pipe_scroller.sv | 117 +++++++++++
 tb/tb_pipe_scroller.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// Shared types and helpers for the pipe-field generator.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Widest column the helper can describe
  localparam int MAX_ROWS = 32;

  // Pipe column for gap start g: lit everywhere except rows g..g+gap-1
  function automatic logic [MAX_ROWS-1:0] gap_pattern(input int g, input int gap, input int rows);
    logic [MAX_ROWS-1:0] p;
    p = '0;
    for (int r = 0; r < MAX_ROWS; r++) begin
      if (r < rows && (r < g || r >= g + gap)) p[r] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/pipe_scroller_if.sv
// Control inputs and frame/score outputs of the pipe scroller.
interface pipe_scroller_if #(
  parameter int ROWS    = 8,
  parameter int COLS    = 16,
  parameter int SCORE_W = 8
) ();

  logic                 start;
  logic                 crash;
  logic [1:0]           speed;
  logic [COLS*ROWS-1:0] frame;
  logic [ROWS-1:0]      bird_col;
  logic                 tick;
  logic                 pass;
  logic [SCORE_W-1:0]   score;
  logic                 running;

  modport master (
    output start, crash, speed,
    input  frame, bird_col, tick, pass, score, running
  );

  modport slave (
    input  start, crash, speed,
    output frame, bird_col, tick, pass, score, running
  );

endinterface

// File: rtl/pipe_scroller_lfsr_gap_gen.sv
// Free-running LFSR and the pipe column it selects.
module lfsr_gap_gen
  import flappy_pkg::*;
#(
  parameter int         ROWS = 8,
  parameter int         GAP  = 3,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  output logic [ROWS-1:0] pattern
);

  localparam int IW     = $clog2(ROWS);
  localparam int MAXPOS = ROWS - GAP;

  logic [7:0] lfsr;
  int         cand;
  int         g;

  // LFSR advances every clock regardless of game state
  always_ff @(posedge clk) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

  // Fold out-of-range candidates back into 0..MAXPOS without a divider
  always_comb begin
    cand    = int'(lfsr[IW-1:0]);
    g       = (cand > MAXPOS) ? cand - (MAXPOS + 1) : cand;
    pattern = ROWS'(gap_pattern(g, GAP, ROWS));
  end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolling pipe field: FSM, tick divider, spacing counter, frame and score.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int         ROWS     = 8,
  parameter int         COLS     = 16,
  parameter int         GAP      = 3,
  parameter int         SPACING  = 4,
  parameter int         PERIOD   = 1024,
  parameter int         BIRD_COL = 2,
  parameter int         SCORE_W  = 8,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input logic            clk,
  input logic            reset,
  pipe_scroller_if.slave bus
);

  localparam int DIV_W = $clog2(PERIOD);
  localparam int SP_W  = $clog2(SPACING);

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic [SP_W-1:0]      sp_cnt;
  logic [COLS*ROWS-1:0] frame;
  logic                 tick;
  logic                 pass;
  logic [SCORE_W-1:0]   score;
  logic [ROWS-1:0]      pattern;
  logic [ROWS-1:0]      new_col;
  logic [31:0]          limit;
  logic                 div_hit;
  logic                 scroll;
  logic                 col0_lit;

  lfsr_gap_gen #(.ROWS(ROWS), .GAP(GAP), .SEED(SEED)) u_gen (
    .clk     (clk),
    .reset   (reset),
    .pattern (pattern)
  );

  // Scroll decision; >= lets a mid-count speed-up fire immediately
  always_comb begin
    limit    = (PERIOD >> bus.speed) - 1;
    div_hit  = (32'(div_cnt) >= limit);
    scroll   = (state == RUN) && !bus.crash && div_hit;
    col0_lit = (frame[ROWS-1:0] != '0);
    new_col  = (sp_cnt == '0) ? pattern : '0;
  end

  // Game state; crash takes priority over a pending scroll
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state <= RUN;
        RUN:     if (bus.crash) state <= FROZEN;
        FROZEN:  if (bus.start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tick divider and pipe spacing counter
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      sp_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!bus.crash) div_cnt <= div_hit ? '0 : div_cnt + 1'b1;
          if (scroll) sp_cnt <= (sp_cnt == SP_W'(SPACING - 1)) ? '0 : sp_cnt + 1'b1;
        end
        FROZEN: begin
          if (bus.start) begin
            div_cnt <= '0;
            sp_cnt  <= '0;
          end
        end
        default: begin
          div_cnt <= '0;
          sp_cnt  <= '0;
        end
      endcase
    end
  end

  // Frame shift register; new columns enter at the right edge
  always_ff @(posedge clk) begin
    if (reset || state == IDLE || (state == FROZEN && bus.start)) frame <= '0;
    else if (scroll)                                             frame <= {new_col, frame[COLS*ROWS-1:ROWS]};
  end

  // Tick/pass pulses and saturating score
  always_ff @(posedge clk) begin
    if (reset) begin
      tick  <= 1'b0;
      pass  <= 1'b0;
      score <= '0;
    end else begin
      tick <= scroll;
      pass <= scroll && col0_lit;
      if (state == IDLE && bus.start)                   score <= '0;
      else if (scroll && col0_lit && score != '1)       score <= score + 1'b1;
    end
  end

  assign bus.frame    = frame;
  assign bus.bird_col = frame[BIRD_COL*ROWS +: ROWS];
  assign bus.tick     = tick;
  assign bus.pass     = pass;
  assign bus.score    = score;
  assign bus.running  = (state == RUN);

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller (ROWS=8 COLS=16 GAP=3 SPACING=4 PERIOD=8).
module tb_pipe_scroller;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pipe_scroller_if #(.ROWS(8), .COLS(16), .SCORE_W(8)) bus ();

  pipe_scroller #(
    .ROWS(8), .COLS(16), .GAP(3), .SPACING(4), .PERIOD(8),
    .BIRD_COL(2), .SCORE_W(8), .SEED(8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev is the value the DUT saw before the latest edge
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected pipe column for an LFSR state (GAP=3, MAXPOS=5)
  function automatic logic [7:0] exp_pat(input logic [7:0] l);
    int cand, g;
    logic [7:0] p;
    cand = int'(l[2:0]);
    g    = (cand > 5) ? cand - 6 : cand;
    p    = 8'h00;
    for (int r = 0; r < 8; r++) p[r] = (r < g) || (r >= g + 3);
    return p;
  endfunction

  task automatic wait_tick(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.tick && cyc < 40);
    chk({tag, "_seen"}, bus.tick, 1'b1);
  endtask

  logic [7:0]   exp_cols [0:20];
  logic [127:0] ef, saved_frame;
  logic [31:0]  pv;
  logic [7:0]   saved_score, ec;
  logic         stable;
  int           cyc, nscore, pcount, sat;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.crash = 1'b0;
    bus.speed = 2'd0;

    // Reset state
    @(negedge clk);
    chk("rst_lfsr", dut.u_gen.lfsr, 8'hA5);
    chk("rst_tick", bus.tick, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_frame", bus.frame, 128'd0);
    chk("idle_score", bus.score, 8'd0);
    chk("idle_running", bus.running, 1'b0);

    // Pattern helper against hand-derived columns
    pv = flappy_pkg::gap_pattern(2, 3, 8); chk("pat_cand2", pv[7:0], 8'b11100011);
    pv = flappy_pkg::gap_pattern(0, 3, 8); chk("pat_cand6", pv[7:0], 8'b11111000);
    pv = flappy_pkg::gap_pattern(1, 3, 8); chk("pat_cand7", pv[7:0], 8'b11110001);

    // Start: first tick 8 cycles after RUN entry
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("run_entry", bus.running, 1'b1);
    wait_tick("tick0", cyc);
    chk("first_tick_lat", cyc, 8);
    exp_cols[0] = exp_pat(m_prev);
    chk("tick0_col15", bus.frame[127:120], exp_cols[0]);
    chk("tick0_pass", bus.pass, 1'b0);

    // Ticks 1..20: spacing, pass at 16 and 20, score 2
    nscore = 0;
    for (int n = 1; n <= 20; n++) begin
      wait_tick("tickn", cyc);
      chk("tick_period", cyc, 8);
      exp_cols[n] = (n % 4 == 0) ? exp_pat(m_prev) : 8'h00;
      chk("col15", bus.frame[127:120], exp_cols[n]);
      chk("pass", bus.pass, (n >= 16 && n % 4 == 0));
      if (n >= 16 && n % 4 == 0) nscore++;
      chk("score", bus.score, nscore);
      if (n == 13) chk("bird_col", bus.bird_col, exp_cols[0]);
    end
    ef = '0;
    for (int c = 0; c < 16; c++) ef[c*8 +: 8] = exp_cols[c + 5];
    chk("frame_t20", bus.frame, ef);
    chk("score_t20", bus.score, 8'd2);

    // Crash on the tick edge
    repeat (7) @(negedge clk);
    chk("div_before_crash", dut.div_cnt, 3'd7);
    bus.crash = 1'b1;
    saved_frame = bus.frame;
    saved_score = bus.score;
    @(negedge clk);
    bus.crash = 1'b0;
    chk("crash_tick", bus.tick, 1'b0);
    chk("crash_pass", bus.pass, 1'b0);
    chk("crash_running", bus.running, 1'b0);
    chk("crash_frame", bus.frame, saved_frame);
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus.frame !== saved_frame || bus.score !== saved_score || bus.tick !== 1'b0) stable = 1'b0;
    end
    chk("frozen_stable", stable, 1'b1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("thaw_frame", bus.frame, 128'd0);
    chk("thaw_running", bus.running, 1'b0);

    // Speed-up mid-count fires on the next cycle, then every cycle
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rerun_score", bus.score, 8'd0);
    repeat (5) @(negedge clk);
    chk("div_mid", dut.div_cnt, 3'd5);
    chk("no_tick_mid", bus.tick, 1'b0);
    bus.speed = 2'd3;
    @(negedge clk);
    chk("speedup_tick", bus.tick, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fast_tick", bus.tick, 1'b1);
    end

    // Score saturation at speed 3
    pcount = 0;
    repeat (1300) begin
      @(negedge clk);
      if (bus.pass) begin
        pcount++;
        sat = (pcount > 255) ? 255 : pcount;
        ec = 8'(sat);
        chk("score_sat", bus.score, ec);
      end
    end
    chk("enough_passes", (pcount >= 258), 1'b1);
    chk("score_held", bus.score, 8'hFF);

    // Reset mid-RUN
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_frame", bus.frame, 128'd0);
    chk("mid_rst_score", bus.score, 8'd0);
    chk("mid_rst_running", bus.running, 1'b0);
    chk("mid_rst_tick", bus.tick, 1'b0);
    chk("mid_rst_pass", bus.pass, 1'b0);
    chk("mid_rst_lfsr", dut.u_gen.lfsr, 8'hA5);
    reset = 1'b0;
    bus.speed = 2'd0;

    // start with crash in IDLE: RUN first, crash taken next cycle
    bus.start = 1'b1;
    bus.crash = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_crash_run", bus.running, 1'b1);
    @(negedge clk);
    chk("start_crash_frozen", bus.running, 1'b0);
    bus.crash = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
